// File: rtl/riscv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : riscv_pkg                                                         |
// | Brief   : Shared RV32I encoder types: instruction formats, NOP, input beat. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_fmt_e;

  // addi x0,x0,0 -- emitted in place of an instruction with an illegal format
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Encoded result carried through the skid buffer: {err, inst}
  localparam int ENC_W = 33;

  typedef struct packed {
    inst_fmt_e   fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_in_t;

endpackage
`default_nettype wire

// File: rtl/riscv_skid_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : riscv_skid_buf                                                    |
// | Brief   : 2-entry in-order valid/ready buffer. in_ready depends only on     |
// |           the occupancy register, so there is no path from out_ready.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module riscv_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Occupancy and storage: head is always the oldest word and drives the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= in_data;
          end else begin
            r_tail <= in_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // push can only coincide with pop at count==1, so the new word becomes head
          r_head <= in_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_inst_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : riscv_inst_encoder                                                |
// | Brief   : Packs decoded RV32I fields into an instruction word, scattering   |
// |           the immediate per format and flagging non-representable values. |
// |           Result is registered through a 2-entry skid buffer.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module riscv_inst_encoder
  import riscv_pkg::*;
#(
  parameter int ERR_CNT_W   = 8,
  parameter int CHECK_RANGE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = ERR_CNT_W'(1);

  // Pack one beat; the immediate is always scattered from its truncated bits,
  // the error flag only reports whether that truncation lost information.
  function automatic logic [ENC_W-1:0] encode(input enc_in_t b);
    logic [31:0] inst;
    logic [31:0] imm;
    logic        bad;
    imm  = b.imm;
    inst = INST_NOP;
    bad  = 1'b0;
    case (b.fmt)
      FMT_R: begin
        inst = {b.funct7, b.rs2, b.rs1, b.funct3, b.rd, b.opcode};
      end
      FMT_I: begin
        inst = {imm[11:0], b.rs1, b.funct3, b.rd, b.opcode};
        bad  = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_S: begin
        inst = {imm[11:5], b.rs2, b.rs1, b.funct3, imm[4:0], b.opcode};
        bad  = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], b.rs2, b.rs1, b.funct3, imm[4:1], imm[11], b.opcode};
        bad  = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], b.rd, b.opcode};
        bad  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], b.rd, b.opcode};
        bad  = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
      end
      default: begin
        inst = INST_NOP;
        bad  = 1'b1;
      end
    endcase
    return {bad && (CHECK_RANGE != 0), inst};
  endfunction

  enc_in_t          w_beat;
  logic [ENC_W-1:0] w_enc;
  logic [ENC_W-1:0] w_buf_data;
  logic             w_accept;

  assign w_beat.fmt    = inst_fmt_e'(in_fmt);
  assign w_beat.opcode = in_opcode;
  assign w_beat.rd     = in_rd;
  assign w_beat.rs1    = in_rs1;
  assign w_beat.rs2    = in_rs2;
  assign w_beat.funct3 = in_funct3;
  assign w_beat.funct7 = in_funct7;
  assign w_beat.imm    = in_imm;

  assign w_enc    = encode(w_beat);
  assign w_accept = in_valid && in_ready;

  riscv_skid_buf #(
    .W (ENC_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_buf_data)
  );

  assign out_err  = w_buf_data[ENC_W-1];
  assign out_inst = w_buf_data[31:0];

  // Count accepted beats that carry an error, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (w_accept && w_enc[ENC_W-1] && (err_cnt != '1)) begin
      err_cnt <= err_cnt + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire
